conv_window_ctrl: RTL and testbench

- Frame-level sequencer for the 3x3 convolution kernels (Gaussian, Laplacian) in the edge-enhancement pipeline.
- Walks every valid 3x3 window of a frame in an input pixel RAM and fetches the 9 pixels.
- Presents the window to a kernel with an enable/done handshake, then writes the kernel result to an output RAM.
- One instance per kernel pass; passes are chained by the top-level with start_i/done_o.

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_addr_gen.sv | 78 +++++++
 rtl/conv_window_ctrl.sv | 158 +++++++++++++++
 tb/tb_conv_window_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 window sequencer.
// State encoding, default frame size, window slot indices.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 240;

  localparam int WIN_N    = 9;
  localparam int K_CENTER = 4;
  localparam int K_LAST   = 8;

  // Slot k of the packed window sits at bits [k*dw +: dw].
  function automatic int win_lsb(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Window walker: r/c/k counters plus incremental RAM addresses.
// Ports: clk, rst, clear, k_step, win_step -> rd_addr, wr_addr, k, flags.
module conv_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int AW    = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          k_step,
  input  logic          win_step,
  output logic [AW-1:0] rd_addr,
  output logic [AW-1:0] wr_addr,
  output logic [3:0]    k,
  output logic          last_k,
  output logic          fetch_end,
  output logic          last_window
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 3);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 3);

  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [1:0]    kcol;
  logic [AW-1:0] base;
  logic [AW-1:0] pix;
  logic [AW-1:0] oaddr;

  // base tracks r*IMG_W+c, pix tracks the address of slot k.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r     <= '0;
      c     <= '0;
      k     <= '0;
      kcol  <= '0;
      base  <= '0;
      pix   <= '0;
      oaddr <= '0;
    end else if (k_step) begin
      k <= k + 4'd1;
      if (kcol == 2'd2) begin
        kcol <= '0;
        pix  <= pix + AW'(IMG_W - 2);
      end else begin
        kcol <= kcol + 2'd1;
        pix  <= pix + AW'(1);
      end
    end else if (win_step) begin
      k     <= '0;
      kcol  <= '0;
      oaddr <= oaddr + AW'(1);
      // Row wrap skips the two right-edge columns.
      if (c == C_LAST) begin
        c    <= '0;
        r    <= r + RW'(1);
        base <= base + AW'(3);
        pix  <= base + AW'(3);
      end else begin
        c    <= c + CW'(1);
        base <= base + AW'(1);
        pix  <= base + AW'(1);
      end
    end
  end

  assign rd_addr     = pix;
  assign wr_addr     = oaddr;
  assign last_k      = (k == 4'(K_LAST));
  assign fetch_end   = (k == 4'(WIN_N));
  assign last_window = (r == R_LAST) && (c == C_LAST);

endmodule

// File: rtl/conv_window_ctrl.sv
// Frame sequencer: fetch 3x3 window, run kernel, write result.
// Ports: start/busy/done/error, input RAM rd_*, kern_*, output RAM wr_*.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W        = DEF_IMG_W,
  parameter int IMG_H        = DEF_IMG_H,
  parameter int DW           = 8,
  parameter int ODW          = 9,
  parameter int AW           = 17,
  parameter int KERN_TIMEOUT = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o,
  output logic            rd_en_o,
  output logic [AW-1:0]   rd_addr_o,
  input  logic [DW-1:0]   rd_data_i,
  output logic [9*DW-1:0] win_o,
  output logic            kern_en_o,
  input  logic            kern_done_i,
  input  logic [ODW-1:0]  kern_data_i,
  output logic            wr_en_o,
  output logic [AW-1:0]   wr_addr_o,
  output logic [ODW-1:0]  wr_data_o
);

  localparam int TW = $clog2(KERN_TIMEOUT + 1);

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] win_q [WIN_N];

  logic          clear;
  logic          k_step;
  logic          win_step;
  logic [AW-1:0] gen_wr_addr;
  logic [3:0]    k;
  logic          last_k;
  logic          fetch_end;
  logic          last_window;

  assign clear    = (state == S_IDLE) && start_i;
  assign k_step   = (state == S_FETCH) && !fetch_end;
  assign win_step = (state == S_WRITE);

  conv_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .AW    (AW)
  ) u_addr (
    .clk         (clk_i),
    .rst         (rst_i),
    .clear       (clear),
    .k_step      (k_step),
    .win_step    (win_step),
    .rd_addr     (rd_addr_o),
    .wr_addr     (gen_wr_addr),
    .k           (k),
    .last_k      (last_k),
    .fetch_end   (fetch_end),
    .last_window (last_window)
  );

  always_comb begin
    win_o = '0;
    for (int j = 0; j < WIN_N; j++) begin
      win_o[win_lsb(j, DW) +: DW] = win_q[j];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      error_o   <= 1'b0;
      rd_en_o   <= 1'b0;
      kern_en_o <= 1'b0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      tcnt      <= '0;
      for (int j = 0; j < WIN_N; j++) begin
        win_q[j] <= '0;
      end
    end else begin
      done_o  <= 1'b0;
      wr_en_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            error_o <= 1'b0;
            busy_o  <= 1'b1;
            rd_en_o <= 1'b1;
            state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Data for read k-1 arrives while k is current.
          for (int j = 0; j < WIN_N; j++) begin
            if (k == 4'(j + 1)) begin
              win_q[j] <= rd_data_i;
            end
          end
          if (last_k) begin
            rd_en_o <= 1'b0;
          end
          if (fetch_end) begin
            kern_en_o <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (kern_done_i) begin
            wr_data_o <= kern_data_i;
            wr_addr_o <= gen_wr_addr;
            wr_en_o   <= 1'b1;
            kern_en_o <= 1'b0;
            state     <= S_WRITE;
          end else if (tcnt == TW'(KERN_TIMEOUT - 1)) begin
            error_o   <= 1'b1;
            kern_en_o <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            state     <= S_DONE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_WRITE: begin
          if (last_window) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= S_DONE;
          end else begin
            rd_en_o <= 1'b1;
            state   <= S_FETCH;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl on a 5x4 frame.
// RAM returns address as data; kernel returns the centre pixel.
module tb_conv_window_ctrl;

  localparam int W   = 5;
  localparam int H   = 4;
  localparam int DW  = 8;
  localparam int ODW = 9;
  localparam int AW  = 17;
  localparam int KT  = 8;
  localparam int NW  = (W - 2) * (H - 2);

  logic            clk = 1'b0;
  logic            rst_i;
  logic            start_i;
  logic            busy_o;
  logic            done_o;
  logic            error_o;
  logic            rd_en_o;
  logic [AW-1:0]   rd_addr_o;
  logic [DW-1:0]   rd_data_i;
  logic [9*DW-1:0] win_o;
  logic            kern_en_o;
  logic            kern_done_i;
  logic [ODW-1:0]  kern_data_i;
  logic            wr_en_o;
  logic [AW-1:0]   wr_addr_o;
  logic [ODW-1:0]  wr_data_o;

  always #5 clk = ~clk;

  conv_window_ctrl #(
    .IMG_W        (W),
    .IMG_H        (H),
    .DW           (DW),
    .ODW          (ODW),
    .AW           (AW),
    .KERN_TIMEOUT (KT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_i   (rd_data_i),
    .win_o       (win_o),
    .kern_en_o   (kern_en_o),
    .kern_done_i (kern_done_i),
    .kern_data_i (kern_data_i),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o)
  );

  int tests = 0;
  int fails = 0;

  int              rq[$];
  int              wqa[$];
  int              wqd[$];
  logic [9*DW-1:0] winq[$];

  int wr_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int ken_cnt = 0;
  int busy_cnt = 0;

  int kmode = 2;
  bit spur = 1'b0;

  task automatic check(string name, logic [71:0] act, logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(int maxc, string name);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!done_o && n < maxc);
    if (!done_o) begin
      tests++;
      fails++;
      $display("FAIL %s: no done_o within %0d cycles", name, maxc);
    end
  endtask

  // Expected stream for the first nwin windows of a pass.
  task automatic push_pass(int nwin, bit with_wr);
    int r;
    int c;
    int a;
    logic [9*DW-1:0] wv;
    for (int i = 0; i < nwin; i++) begin
      r  = i / (W - 2);
      c  = i % (W - 2);
      wv = '0;
      for (int k = 0; k < 9; k++) begin
        a = (r + k / 3) * W + c + k % 3;
        rq.push_back(a);
        wv[k*DW +: DW] = DW'(a);
      end
      winq.push_back(wv);
      if (with_wr) begin
        wqa.push_back(r * (W - 2) + c);
        wqd.push_back((r + 1) * W + c + 1);
      end
    end
  endtask

  // Input RAM: one-cycle read latency, data = address.
  initial begin
    logic          e;
    logic [AW-1:0] a;
    rd_data_i = '0;
    forever begin
      @(negedge clk);
      e = rd_en_o;
      a = rd_addr_o;
      @(posedge clk);
      #1;
      rd_data_i = e ? a[DW-1:0] : 8'hEE;
    end
  end

  // Kernel: done kmode cycles after enable; kmode 0 never answers.
  initial begin
    int kc;
    kc = 0;
    kern_done_i = 1'b0;
    kern_data_i = '0;
    forever begin
      @(negedge clk);
      kc = kern_en_o ? kc + 1 : 0;
      kern_done_i = (kern_en_o && kmode > 0 && kc == kmode + 1)
                 || (spur && rd_en_o);
      kern_data_i = ODW'(win_o[4*DW +: DW]);
    end
  end

  // Monitor: pops expectations whenever the DUT presents something.
  initial begin
    logic ken_prev;
    ken_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_en_o) begin
        rd_cnt++;
        if (rq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_unexpected: got addr %0d, expected no read", rd_addr_o);
        end else begin
          check("rd_addr", rd_addr_o, rq.pop_front());
        end
      end
      if (wr_en_o) begin
        wr_cnt++;
        if (wqa.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wr_unexpected: got addr %0d data %0d, expected no write",
                   wr_addr_o, wr_data_o);
        end else begin
          check("wr_addr", wr_addr_o, wqa.pop_front());
          check("wr_data", wr_data_o, wqd.pop_front());
        end
      end
      if (kern_en_o && !ken_prev) begin
        if (winq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL issue_unexpected: got win %0h, expected no issue", win_o);
        end else begin
          check("win_at_issue", win_o, winq.pop_front());
        end
      end
      ken_prev = kern_en_o;
      if (kern_en_o) ken_cnt++;
      if (done_o) done_cnt++;
      if (busy_o) busy_cnt++;
    end
  end

  initial begin
    int w0;
    int d0;
    int b0;
    int k0;
    int r0;
    int n;
    rst_i   = 1'b1;
    start_i = 1'b0;
    repeat (3) cyc();
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_rd_en", rd_en_o, 0);
    check("rst_rd_addr", rd_addr_o, 0);
    check("rst_win", win_o, 0);
    check("rst_kern_en", kern_en_o, 0);
    check("rst_wr_en", wr_en_o, 0);
    check("rst_wr_addr", wr_addr_o, 0);
    check("rst_wr_data", wr_data_o, 0);
    rst_i = 1'b0;
    cyc();

    // Full pass, kernel latency 2.
    kmode = 2;
    w0 = wr_cnt; d0 = done_cnt; b0 = busy_cnt;
    push_pass(NW, 1'b1);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    wait_done(400, "pass_lat2");
    check("A_error", error_o, 0);
    cyc();
    cyc();
    check("A_writes", wr_cnt - w0, NW);
    check("A_done_pulses", done_cnt - d0, 1);
    check("A_busy_after", busy_o, 0);
    check("A_busy_cycles", busy_cnt - b0, NW * 14);
    check("A_rq_empty", rq.size(), 0);
    check("A_wq_empty", wqa.size(), 0);

    // Kernel never answers: timeout abort.
    kmode = 0;
    w0 = wr_cnt; d0 = done_cnt; k0 = ken_cnt;
    push_pass(1, 1'b0);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    wait_done(100, "pass_timeout");
    check("B_error_set", error_o, 1);
    check("B_kern_en_cycles", ken_cnt - k0, 1 + KT);
    cyc();
    check("B_error_sticky", error_o, 1);
    check("B_writes", wr_cnt - w0, 0);
    check("B_done_pulses", done_cnt - d0, 1);
    check("B_rq_empty", rq.size(), 0);

    // start held high, spurious done during fetch, latency 1.
    kmode = 1;
    spur  = 1'b1;
    w0 = wr_cnt; d0 = done_cnt; b0 = busy_cnt;
    push_pass(NW, 1'b1);
    push_pass(NW, 1'b1);
    start_i = 1'b1;
    cyc();
    check("C_error_cleared", error_o, 0);
    check("C_busy", busy_o, 1);
    wait_done(400, "pass_held1");
    cyc();
    check("C_idle_no_rd", rd_en_o, 0);
    check("C_idle_not_busy", busy_o, 0);
    cyc();
    check("C_restart_rd", rd_en_o, 1);
    start_i = 1'b0;
    wait_done(400, "pass_held2");
    spur = 1'b0;
    cyc();
    cyc();
    check("C_writes", wr_cnt - w0, 2 * NW);
    check("C_done_pulses", done_cnt - d0, 2);
    check("C_busy_cycles", busy_cnt - b0, 2 * NW * 13);
    check("C_wq_empty", wqa.size(), 0);

    // Reset during window 3 fetch.
    kmode = 1;
    w0 = wr_cnt;
    push_pass(NW, 1'b1);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    n = 0;
    while (wr_cnt - w0 < 3 && n < 200) begin
      cyc();
      n++;
    end
    check("D_three_writes", wr_cnt - w0, 3);
    repeat (3) cyc();
    rst_i = 1'b1;
    cyc();
    check("D_rst_busy", busy_o, 0);
    check("D_rst_rd_en", rd_en_o, 0);
    check("D_rst_rd_addr", rd_addr_o, 0);
    check("D_rst_kern_en", kern_en_o, 0);
    check("D_rst_wr_en", wr_en_o, 0);
    check("D_rst_wr_addr", wr_addr_o, 0);
    check("D_rst_win", win_o, 0);
    check("D_rst_done", done_o, 0);
    rst_i = 1'b0;
    rq.delete();
    wqa.delete();
    wqd.delete();
    winq.delete();
    d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
    repeat (40) cyc();
    check("D_no_done", done_cnt - d0, 0);
    check("D_no_reads", rd_cnt - r0, 0);
    check("D_no_writes", wr_cnt - w0, 0);
    check("D_idle", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
